// File: rtl/mult_issue_ctrl_if.sv
// Handshake bundle between the multiplier issue controller and its neighbours:
// operand stream in, start/done to the multiplier, result FIFO out.
interface mult_issue_ctrl_if #(
    parameter int OP_W  = 8,
    parameter int RES_W = 16,
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             start;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             done;
    logic [RES_W-1:0] res_in;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic             out_err;
    logic             busy;
    logic [FW-1:0]    fill;

    modport master (
        input  in_valid, in_a, in_b, done, res_in, out_ready,
        output in_ready, start, op_a, op_b, out_valid, out_data, out_err, busy, fill
    );

    modport slave (
        output in_valid, in_a, in_b, done, res_in, out_ready,
        input  in_ready, start, op_a, op_b, out_valid, out_data, out_err, busy, fill
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issues operand pairs to a start/done shift multiplier and queues each result,
// or a timeout marker, in a small circular output FIFO.
module mult_issue_ctrl #(
    parameter int OP_W  = 8,
    parameter int RES_W = 16,
    parameter int DEPTH = 4,
    parameter int TMO   = 64
) (
    input  logic              clk,
    input  logic              rst,
    mult_issue_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL     = FW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_CAPT  = 5'b01000,
        S_STALL = 5'b10000
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_cnt;
    logic [OP_W-1:0]  r_op_a;
    logic [OP_W-1:0]  r_op_b;
    logic [RES_W-1:0] r_res;
    logic             r_err;
    logic [RES_W:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [FW-1:0]    r_fill;
    logic [RES_W:0]   w_head;
    logic             w_full;
    logic             w_nonempty;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_tmo;

    assign w_full     = (r_fill == FULL);
    assign w_nonempty = (r_fill != '0);
    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_push     = (r_state == S_CAPT);
    assign w_pop      = w_nonempty & bus.out_ready;
    assign w_tmo      = (r_cnt == TMO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = S_ISSUE;
                else if (bus.in_valid && w_full)
                    w_next = S_STALL;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.done || w_tmo) w_next = S_CAPT;
            S_CAPT:  w_next = S_IDLE;
            S_STALL: if (!w_full) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ISSUE)
                r_cnt <= '0;
            else if (r_state == S_WAIT && !bus.done)
                r_cnt <= r_cnt + 8'd1;
            if (w_accept) begin
                r_op_a <= bus.in_a;
                r_op_b <= bus.in_b;
            end
        end
    end

    // done has priority over an expiring counter in the same cycle
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT) begin
            if (bus.done) begin
                r_res <= bus.res_in;
                r_err <= 1'b0;
            end else if (w_tmo) begin
                r_res <= '0;
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {r_err, r_res};
    end

    assign w_head = r_mem[r_rd];

    // handshake outputs are masked during reset so nothing is issued or accepted
    assign bus.in_ready  = (r_state == S_IDLE) && !w_full && !rst;
    assign bus.start     = (r_state == S_ISSUE) && !rst;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.out_valid = w_nonempty;
    assign bus.out_data  = w_nonempty ? w_head[RES_W-1:0] : '0;
    assign bus.out_err   = w_nonempty & w_head[RES_W];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.fill      = r_fill;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl; the multiplier side is played by the tasks.
module tb_mult_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_issue_ctrl_if #(.OP_W(8), .RES_W(16), .DEPTH(4)) bus ();

    mult_issue_ctrl #(.OP_W(8), .RES_W(16), .DEPTH(4), .TMO(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input int a, input int b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'(a);
        bus.in_b     = 8'(b);
        while (bus.in_ready !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_mult(input int lat, input int hold, input int res);
        int t = 0;
        repeat (lat) tick();
        bus.done   = 1'b1;
        bus.res_in = 16'(res);
        repeat (hold) tick();
        bus.done   = 1'b0;
        bus.res_in = '0;
        while (bus.busy === 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", bus.busy, t);
        end
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b want 0", bus.start); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.fill !== 3'd0) begin n_bad++; $display("FAIL rst_fill: got %0d want 0", bus.fill); end
        n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_data} !== 18'd0) begin n_bad++;
            $display("FAIL rst_out: got valid=%b err=%b data=%0d want 0/0/0", bus.out_valid, bus.out_err, bus.out_data); end
        n_cmp++; if ({bus.op_a, bus.op_b} !== 16'd0) begin n_bad++; $display("FAIL rst_ops: got %0d/%0d want 0/0", bus.op_a, bus.op_b); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        int n_start = 0;
        int unstable = 0;
        send_pair(3, 5);
        n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b want 1", bus.start); end
        n_cmp++; if (bus.op_a !== 8'd3 || bus.op_b !== 8'd5) begin n_bad++; $display("FAIL op_latch: got %0d/%0d want 3/5", bus.op_a, bus.op_b); end
        repeat (6) begin
            tick();
            if (bus.start === 1'b1) n_start++;
            if (bus.op_a !== 8'd3 || bus.op_b !== 8'd5) unstable++;
        end
        bus.done = 1'b1; bus.res_in = 16'd15;
        tick();
        bus.done = 1'b0; bus.res_in = '0;
        if (bus.op_a !== 8'd3 || bus.op_b !== 8'd5) unstable++;
        tick();
        n_cmp++; if (n_start !== 0) begin n_bad++; $display("FAIL extra_start: got %0d extra pulses want 0", n_start); end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL op_stable: got %0d unstable cycles want 0", unstable); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd15 || bus.out_err !== 1'b0) begin n_bad++;
            $display("FAIL t1_result: got valid=%b data=%0d err=%b want 1/15/0", bus.out_valid, bus.out_data, bus.out_err); end
        n_cmp++; if (bus.fill !== 3'd1) begin n_bad++; $display("FAIL t1_fill: got %0d want 1", bus.fill); end
        pop_one();
        n_cmp++; if (bus.fill !== 3'd0 || bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL t1_pop: got fill=%0d valid=%b want 0/0", bus.fill, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int exp_q[4] = '{4, 6, 8, 21};
        int n_start = 0;
        for (int i = 0; i < 4; i++) begin
            send_pair(i + 1, 2);
            finish_mult(2, 1, (i + 1) * 2);
        end
        n_cmp++; if (bus.fill !== 3'd4 || bus.in_ready !== 1'b0) begin n_bad++;
            $display("FAIL t2_full: got fill=%0d in_ready=%b want 4/0", bus.fill, bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_a = 8'd7; bus.in_b = 8'd3;
        repeat (4) begin
            tick();
            if (bus.start === 1'b1) n_start++;
        end
        n_cmp++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || n_start !== 0) begin n_bad++;
            $display("FAIL t2_stall: got busy=%b in_ready=%b starts=%0d want 1/0/0", bus.busy, bus.in_ready, n_start); end
        n_cmp++; if (bus.out_data !== 16'd2) begin n_bad++; $display("FAIL t2_head: got %0d want 2", bus.out_data); end
        pop_one();
        n_cmp++; if (bus.fill !== 3'd3 || bus.out_data !== 16'd4) begin n_bad++;
            $display("FAIL t2_pop: got fill=%0d data=%0d want 3/4", bus.fill, bus.out_data); end
        send_pair(7, 3);
        finish_mult(2, 1, 21);
        n_cmp++; if (bus.fill !== 3'd4) begin n_bad++; $display("FAIL t2_refill: got %0d want 4", bus.fill); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.out_data !== 16'(exp_q[k])) begin n_bad++;
                $display("FAIL t2_order%0d: got %0d want %0d", k, bus.out_data, exp_q[k]); end
            pop_one();
        end
        n_cmp++; if (bus.fill !== 3'd0 || bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL t2_drain: got fill=%0d valid=%b want 0/0", bus.fill, bus.out_valid); end
    endtask

    task automatic test_timeout();
        int n = 0;
        send_pair(9, 9);
        while (bus.fill === 3'd0 && n < 100) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 66) begin n_bad++; $display("FAIL t3_latency: got %0d cycles start-to-entry want 66", n); end
        n_cmp++; if (bus.out_err !== 1'b1 || bus.out_data !== 16'd0) begin n_bad++;
            $display("FAIL t3_entry: got err=%b data=%0d want 1/0", bus.out_err, bus.out_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t3_idle: got busy=%b want 0", bus.busy); end
        pop_one();
        send_pair(2, 3);
        finish_mult(3, 1, 6);
        n_cmp++; if (bus.out_data !== 16'd6 || bus.out_err !== 1'b0 || bus.fill !== 3'd1) begin n_bad++;
            $display("FAIL t3_next: got data=%0d err=%b fill=%0d want 6/0/1", bus.out_data, bus.out_err, bus.fill); end
        pop_one();
    endtask

    task automatic test_done_hold();
        send_pair(5, 6);
        finish_mult(2, 3, 30);
        n_cmp++; if (bus.fill !== 3'd1 || bus.out_data !== 16'd30) begin n_bad++;
            $display("FAIL t4_single_push: got fill=%0d data=%0d want 1/30", bus.fill, bus.out_data); end
        bus.done = 1'b1; bus.res_in = 16'd99;
        tick();
        tick();
        bus.done = 1'b0; bus.res_in = '0;
        tick();
        n_cmp++; if (bus.fill !== 3'd1 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL t4_idle_done: got fill=%0d busy=%b want 1/0", bus.fill, bus.busy); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        int n_start = 0;
        send_pair(1, 1);
        finish_mult(1, 1, 1);
        send_pair(4, 4);
        repeat (3) tick();
        n_cmp++; if (bus.busy !== 1'b1 || bus.fill !== 3'd1) begin n_bad++;
            $display("FAIL t5_pre: got busy=%b fill=%0d want 1/1", bus.busy, bus.fill); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({bus.in_ready, bus.start, bus.busy, bus.out_valid, bus.out_err} !== 5'd0) begin n_bad++;
            $display("FAIL t5_ctrl: got rdy=%b start=%b busy=%b valid=%b err=%b want all 0",
                     bus.in_ready, bus.start, bus.busy, bus.out_valid, bus.out_err); end
        n_cmp++; if (bus.fill !== 3'd0 || bus.out_data !== 16'd0 || {bus.op_a, bus.op_b} !== 16'd0) begin n_bad++;
            $display("FAIL t5_data: got fill=%0d data=%0d ops=%0d/%0d want 0", bus.fill, bus.out_data, bus.op_a, bus.op_b); end
        rst = 1'b0;
        repeat (8) begin
            tick();
            if (bus.start === 1'b1) n_start++;
        end
        n_cmp++; if (n_start !== 0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL t5_post: got starts=%0d busy=%b in_ready=%b want 0/0/1", n_start, bus.busy, bus.in_ready); end
    endtask

    task automatic test_push_pop();
        int q[$];
        send_pair(1, 1); finish_mult(1, 1, 1); q.push_back(1);
        send_pair(2, 2); finish_mult(1, 1, 4); q.push_back(4);
        for (int k = 0; k < 3; k++) begin
            int a = k + 3;
            send_pair(a, a);
            repeat (2) tick();
            bus.done = 1'b1; bus.res_in = 16'(a * a);
            tick();
            bus.done = 1'b0; bus.res_in = '0;
            n_cmp++; if (bus.out_data !== 16'(q[0])) begin n_bad++;
                $display("FAIL t6_head%0d: got %0d want %0d", k, bus.out_data, q[0]); end
            void'(q.pop_front());
            q.push_back(a * a);
            pop_one();
            n_cmp++; if (bus.fill !== 3'd2 || bus.out_data !== 16'(q[0])) begin n_bad++;
                $display("FAIL t6_pushpop%0d: got fill=%0d data=%0d want 2/%0d", k, bus.fill, bus.out_data, q[0]); end
        end
        while (q.size() > 0) begin
            n_cmp++; if (bus.out_data !== 16'(q[0]) || bus.out_valid !== 1'b1) begin n_bad++;
                $display("FAIL t6_drain: got valid=%b data=%0d want 1/%0d", bus.out_valid, bus.out_data, q[0]); end
            void'(q.pop_front());
            pop_one();
        end
        n_cmp++; if (bus.fill !== 3'd0) begin n_bad++; $display("FAIL t6_empty: got %0d want 0", bus.fill); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.done      = 1'b0;
        bus.res_in    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_done_hold();
        test_reset_mid();
        test_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
